// File: rtl/c_hazard_unit.sv
// Hazard controller: forwarding selects, load-use/RAW stalls, branch flushes and mul/div E occupancy.
// Define HAZARD_FORWARDING_EN for E-stage forwarding; otherwise RAW hazards on D sources stall instead.
module c_hazard_unit #(
    parameter int MD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       MulDivE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       MdBusyE,
    output logic       MdDoneE
);

    typedef enum logic {IDLE, BUSY} state_t;

    // cnt is kept at least one bit wide so MD_CYCLES of 1 or 2 still elaborate
    localparam int CW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam bit MD_MULTI = (MD_CYCLES > 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((MD_CYCLES > 1) ? MD_CYCLES - 2 : 0);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          md_stall;
    logic          data_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        md_stall = 1'b0;
        MdDoneE  = 1'b0;
        case (state)
            IDLE: begin
                if (MulDivE && MD_MULTI) begin
                    state_n  = BUSY;
                    cnt_n    = CNT_INIT;
                    md_stall = 1'b1;
                end
                if (MulDivE && !MD_MULTI) MdDoneE = 1'b1;
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n    = cnt - 1'b1;
                    md_stall = 1'b1;
                end else begin
                    // instruction leaves E on this edge
                    state_n = IDLE;
                    MdDoneE = MulDivE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef HAZARD_FORWARDING_EN
    logic unused_inputs;
    assign unused_inputs = RegWriteE;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)      ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)      ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ForwardBE = 2'b01;
    end

    assign data_stall = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
`else
    logic unused_inputs;
    assign unused_inputs = ^{Rs1E, Rs2E, RdW, RegWriteW, LoadE};

    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;

    // W writes the regfile in the first half-cycle, so only E and M producers block D
    assign data_stall =
        (Rs1D != 5'd0 && ((RegWriteE && RdE == Rs1D) || (RegWriteM && RdM == Rs1D))) ||
        (Rs2D != 5'd0 && ((RegWriteE && RdE == Rs2D) || (RegWriteM && RdM == Rs2D)));
`endif

    assign StallF  = data_stall || md_stall;
    assign StallD  = data_stall || md_stall;
    assign StallE  = md_stall;
    assign FlushD  = PCSrcE && !md_stall;
    assign FlushE  = (data_stall || PCSrcE) && !md_stall;
    assign FlushM  = md_stall;
    assign MdBusyE = (state == BUSY);

endmodule
